// File: rtl/earom_ioctl_upload.sv
// Serves hps_io upload reads from the high-score EAROM shadow RAM. While an upload is
// active it keeps the core off the shared RAM read port and tracks unsaved changes.
module earom_ioctl_upload #(
  parameter int unsigned AW       = 6,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  NV_INDEX = 8'd4,
  parameter logic [7:0]  FILL     = 8'hFF
) (
  input  logic          clk_25,
  input  logic          RESET_L,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          core_we,
  output logic          core_hold,
  output logic          nv_dirty,
  output logic [AW:0]   up_count
);

  localparam logic [AW:0] Full = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StHold, StRdWait} state_e;

  state_e      state_q;
  logic [1:0]  lat_cnt_q;
  logic        seq_q;
  logic        sel;
  logic        in_range;
  logic        addr_is_next;
  logic        lat_done;
  logic [AW:0] up_next;
  logic        close_full;

  assign sel          = ioctl_upload & (ioctl_index == NV_INDEX);
  assign in_range     = ~|ioctl_addr[24:AW];
  assign addr_is_next = ({1'b0, ioctl_addr[AW-1:0]} == up_count) && (up_count != Full);
  assign lat_done     = (lat_cnt_q == 2'(RD_LAT));
  assign up_next      = up_count + (AW+1)'(seq_q);

  // A session closing with every byte read in order counts as a complete save.
  assign close_full = ((state_q == StHold) && !sel && (up_count == Full)) ||
                      ((state_q == StRdWait) && lat_done && !sel && (up_next == Full));

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= StIdle;
      lat_cnt_q  <= 2'd0;
      seq_q      <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      core_hold  <= 1'b0;
      nv_dirty   <= 1'b0;
      up_count   <= '0;
    end else begin
      ram_rd <= 1'b0;

      if (core_we) begin
        nv_dirty <= 1'b1;
      end else if (close_full) begin
        nv_dirty <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (sel) begin
            state_q   <= StHold;
            core_hold <= 1'b1;
          end
        end
        StHold: begin
          if (!sel) begin
            state_q   <= StIdle;
            core_hold <= 1'b0;
            up_count  <= '0;
          end else if (ioctl_rd) begin
            if (in_range) begin
              ram_addr   <= ioctl_addr[AW-1:0];
              ram_rd     <= 1'b1;
              ioctl_wait <= 1'b1;
              lat_cnt_q  <= 2'd0;
              seq_q      <= addr_is_next;
              state_q    <= StRdWait;
            end else begin
              ioctl_din <= FILL;
            end
          end
        end
        StRdWait: begin
          // Strobes arriving here violate the wait handshake and are dropped.
          if (lat_done) begin
            ioctl_din  <= ram_q;
            ioctl_wait <= 1'b0;
            seq_q      <= 1'b0;
            if (sel) begin
              state_q  <= StHold;
              up_count <= up_next;
            end else begin
              state_q   <= StIdle;
              core_hold <= 1'b0;
              up_count  <= '0;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_earom_ioctl_upload.sv
// Scoreboard bench for earom_ioctl_upload: reads queue expected bytes, a monitor checks
// them when ioctl_wait drops. A second instance with RD_LAT=3 covers mid-read reset.
module tb_earom_ioctl_upload;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic        core_we = 1'b0;

  logic [7:0]  din1, din3;
  logic        wait1, wait3;
  logic [5:0]  raddr1, raddr3;
  logic        rrd1, rrd3;
  logic [7:0]  rq1, rq3;
  logic        hold1, hold3;
  logic        dirty1, dirty3;
  logic [6:0]  upc1, upc3;
  logic [7:0]  s0, s1, s2;

  always #5 clk = ~clk;

  earom_ioctl_upload #(.AW(6), .RD_LAT(1), .NV_INDEX(8'd4), .FILL(8'hFF)) u_dut (
    .clk_25(clk), .RESET_L(rst_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1),
    .ram_addr(raddr1), .ram_rd(rrd1), .ram_q(rq1), .core_we(core_we), .core_hold(hold1),
    .nv_dirty(dirty1), .up_count(upc1)
  );

  earom_ioctl_upload #(.AW(6), .RD_LAT(3), .NV_INDEX(8'd4), .FILL(8'hFF)) u_dut3 (
    .clk_25(clk), .RESET_L(rst3_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(wait3),
    .ram_addr(raddr3), .ram_rd(rrd3), .ram_q(rq3), .core_we(core_we), .core_hold(hold3),
    .nv_dirty(dirty3), .up_count(upc3)
  );

  // RAM models: contents are addr ^ 8'h5A
  always @(posedge clk) if (rrd1) rq1 <= {2'b00, raddr1} ^ 8'h5A;
  always @(posedge clk) begin
    if (rrd3) s0 <= {2'b00, raddr3} ^ 8'h5A;
    s1 <= s0;
    s2 <= s1;
  end
  assign rq3 = s2;

  int rd_seen = 0;
  always @(posedge clk) if (rrd1) rd_seen <= rd_seen + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         waits;
  } exp_t;

  exp_t exp_q[$];
  logic busy = 1'b0;

  // Monitor: pops on an accepted strobe, then waits for ioctl_wait low and compares.
  initial begin
    exp_t cur;
    int   waits;
    bit   done;
    forever begin
      @(posedge clk);
      if (ioctl_rd && exp_q.size() > 0) begin
        cur   = exp_q.pop_front();
        busy  = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
          @(negedge clk);
          if (wait1) waits++;
          else done = 1'b1;
        end
        check("rd_complete", 32'(done), 32'd1);
        check("rd_data", 32'(din1), 32'(cur.data));
        check("rd_wait_clks", 32'(waits), 32'(cur.waits));
        busy = 1'b0;
      end
    end
  end

  task automatic do_read(input logic [24:0] a, input logic [7:0] d, input int w);
    bit ok;
    exp_q.push_back('{data: d, waits: w});
    @(posedge clk); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      exp_q.delete();
      check("rd_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic strobe(input logic [24:0] a);
    @(posedge clk); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
  endtask

  task automatic open_session(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic close_session();
    @(posedge clk); #1;
    ioctl_upload = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pulse_we();
    @(posedge clk); #1;
    core_we = 1'b1;
    @(posedge clk); #1;
    core_we = 1'b0;
  endtask

  task automatic read_range(input int first, input int last);
    for (int a = first; a <= last; a++) do_read(25'(a), 8'(a) ^ 8'h5A, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_din", 32'(din1), 32'h00);
    check("rst_wait", 32'(wait1), 32'd0);
    check("rst_ram_rd", 32'(rrd1), 32'd0);
    check("rst_ram_addr", 32'(raddr1), 32'd0);
    check("rst_hold", 32'(hold1), 32'd0);
    check("rst_dirty", 32'(dirty1), 32'd0);
    check("rst_up_count", 32'(upc1), 32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: full sequential upload
    open_session(8'd4);
    check("t1_hold", 32'(hold1), 32'd1);
    read_range(0, 63);
    check("t1_up_count", 32'(upc1), 32'd64);
    close_session();
    check("t1_hold_off", 32'(hold1), 32'd0);
    check("t1_up_clear", 32'(upc1), 32'd0);
    check("t1_dirty", 32'(dirty1), 32'd0);

    // 2: dirty cleared by a complete upload
    open_session(8'd4);
    pulse_we();
    check("t2_dirty_set", 32'(dirty1), 32'd1);
    read_range(0, 63);
    check("t2_dirty_held", 32'(dirty1), 32'd1);
    close_session();
    check("t2_dirty_clr", 32'(dirty1), 32'd0);

    // 3: partial upload keeps dirty
    pulse_we();
    open_session(8'd4);
    read_range(0, 31);
    check("t3_up_count", 32'(upc1), 32'd32);
    close_session();
    check("t3_dirty", 32'(dirty1), 32'd1);
    check("t3_up_clear", 32'(upc1), 32'd0);

    // 4: out-of-range fill, out-of-order addr not counted
    open_session(8'd4);
    do_read(25'd100, 8'hFF, 0);
    do_read(25'd64, 8'hFF, 0);
    do_read(25'h100_0000, 8'hFF, 0);
    do_read(25'd5, 8'h5F, 2);
    check("t4_ooo_count", 32'(upc1), 32'd0);
    do_read(25'd0, 8'h5A, 2);
    check("t4_seq_count", 32'(upc1), 32'd1);
    close_session();
    check("t4_dirty", 32'(dirty1), 32'd1);

    // 5: wrong index ignored
    rd_seen = 0;
    open_session(8'd0);
    strobe(25'd0);
    strobe(25'd1);
    strobe(25'd2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_hold", 32'(hold1), 32'd0);
    check("t5_ram_rd", 32'(rd_seen), 32'd0);
    check("t5_wait", 32'(wait1), 32'd0);
    close_session();

    // 6: reset during RDWAIT on the RD_LAT=3 instance
    open_session(8'd4);
    check("t6_hold3", 32'(hold3), 32'd1);
    strobe(25'd7);
    check("t6_ram_rd3", 32'(rrd3), 32'd1);
    check("t6_wait3", 32'(wait3), 32'd1);
    @(posedge clk); #1;
    check("t6_wait3_mid", 32'(wait3), 32'd1);
    rst3_n = 1'b0;
    #1;
    check("t6_rst_wait3", 32'(wait3), 32'd0);
    check("t6_rst_hold3", 32'(hold3), 32'd0);
    check("t6_rst_ram_rd3", 32'(rrd3), 32'd0);
    check("t6_rst_din3", 32'(din3), 32'h00);
    check("t6_rst_up3", 32'(upc3), 32'd0);
    @(posedge clk); #1;
    rst3_n = 1'b1;
    close_session();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
